// File: rtl/rx_pcs_pkg.sv
// rx_pcs_pkg: shared constants, lock-state and sub-block disparity types for the 8b/10b receive path
package rx_pcs_pkg;
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [7:0] EDB_BYTE = 8'hFE;
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  // DISP_0P/DISP_0N are the neutral blocks that still pin RD (000111/0011 and 111000/1100)
  typedef enum logic [2:0] {DISP_0, DISP_P2, DISP_M2, DISP_0P, DISP_0N} disp_e;
  // Blocks with an impossible weight are already code errors; they are treated as neutral
  function automatic disp_e disp6(input logic [5:0] b);
    int n;
    n = $countones(b);
    return n == 4 ? DISP_P2 : n == 2 ? DISP_M2 : b == 6'b000111 ? DISP_0P : b == 6'b111000 ? DISP_0N : DISP_0;
  endfunction
  function automatic disp_e disp4(input logic [3:0] b);
    int n;
    n = $countones(b);
    return n == 3 ? DISP_P2 : n == 1 ? DISP_M2 : b == 4'b0011 ? DISP_0P : b == 4'b1100 ? DISP_0N : DISP_0;
  endfunction
endpackage

// File: rtl/rx_decoder_10b8b_if.sv
// rx_decoder_10b8b_if: symbol input and decoded output bundle of the receive decoder
//   Data_to_Decoder/K285 : aligned symbol (abcdei fghj) and comma flag from the deserialiser
//   Data_out/DataK       : decoded byte (HGF EDCBA) and control flag
//   Decode_Error/Disparity_Error/RxValid : error flags and symbol-lock indicator
interface rx_decoder_10b8b_if;
  logic [9:0] Data_to_Decoder;
  logic       K285;
  logic [7:0] Data_out;
  logic       DataK;
  logic       Decode_Error;
  logic       Disparity_Error;
  logic       RxValid;
  modport master(output Data_to_Decoder, K285, input Data_out, DataK, Decode_Error, Disparity_Error, RxValid);
  modport slave(input Data_to_Decoder, K285, output Data_out, DataK, Decode_Error, Disparity_Error, RxValid);
endinterface

// File: rtl/dec_10b8b_lut.sv
// dec_10b8b_lut: combinational 10b->8b table lookup with K/valid flags and sub-block disparity classes
//   sym : abcdei fghj (bit 9 = a)   d5/d3 : EDCBA / HGF   k : control code   ok : symbol in table
//   c6/c4 : disparity class of the 6b and 4b sub-blocks
module dec_10b8b_lut
  import rx_pcs_pkg::*;
(
  input  logic [9:0] sym,
  output logic [4:0] d5,
  output logic [2:0] d3,
  output logic       k,
  output logic       ok,
  output disp_e      c6,
  output disp_e      c4
);
  logic [5:0] s6;
  logic [3:0] s4, kf;
  logic [2:0] d3d, d3k;
  logic ok6, ok4k, k28, a7, sa, sb, sk, kx7, ok4d;
  assign s6 = sym[9:4];
  assign s4 = sym[3:0];
  assign c6 = disp6(s6);
  assign c4 = disp4(s4);
  always_comb begin
    d5 = 5'd0;
    ok6 = 1'b1;
    k28 = 1'b0;
    case (s6)
      6'b100111, 6'b011000: d5 = 5'd0;
      6'b011101, 6'b100010: d5 = 5'd1;
      6'b101101, 6'b010010: d5 = 5'd2;
      6'b110001:            d5 = 5'd3;
      6'b110101, 6'b001010: d5 = 5'd4;
      6'b101001:            d5 = 5'd5;
      6'b011001:            d5 = 5'd6;
      6'b111000, 6'b000111: d5 = 5'd7;
      6'b111001, 6'b000110: d5 = 5'd8;
      6'b100101:            d5 = 5'd9;
      6'b010101:            d5 = 5'd10;
      6'b110100:            d5 = 5'd11;
      6'b001101:            d5 = 5'd12;
      6'b101100:            d5 = 5'd13;
      6'b011100:            d5 = 5'd14;
      6'b010111, 6'b101000: d5 = 5'd15;
      6'b011011, 6'b100100: d5 = 5'd16;
      6'b100011:            d5 = 5'd17;
      6'b010011:            d5 = 5'd18;
      6'b110010:            d5 = 5'd19;
      6'b001011:            d5 = 5'd20;
      6'b101010:            d5 = 5'd21;
      6'b011010:            d5 = 5'd22;
      6'b111010, 6'b000101: d5 = 5'd23;
      6'b110011, 6'b001100: d5 = 5'd24;
      6'b100110:            d5 = 5'd25;
      6'b010110:            d5 = 5'd26;
      6'b110110, 6'b001001: d5 = 5'd27;
      6'b001110:            d5 = 5'd28;
      6'b101110, 6'b010001: d5 = 5'd29;
      6'b011110, 6'b100001: d5 = 5'd30;
      6'b101011, 6'b010100: d5 = 5'd31;
      6'b001111, 6'b110000: begin
        d5 = 5'd28;
        k28 = 1'b1;
      end
      default: ok6 = 1'b0;
    endcase
  end
  always_comb begin
    d3d = 3'd0;
    case (s4)
      4'b1001: d3d = 3'd1;
      4'b0101: d3d = 3'd2;
      4'b1100, 4'b0011: d3d = 3'd3;
      4'b1101, 4'b0010: d3d = 3'd4;
      4'b1010: d3d = 3'd5;
      4'b0110: d3d = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: d3d = 3'd7;
      default: d3d = 3'd0;
    endcase
  end
  // K28.y fghj after 110000 is the complement of the form after 001111, so fold onto one table
  assign kf = s6 == 6'b110000 ? ~s4 : s4;
  always_comb begin
    d3k = 3'd0;
    ok4k = 1'b1;
    case (kf)
      4'b0100: d3k = 3'd0;
      4'b1001: d3k = 3'd1;
      4'b0101: d3k = 3'd2;
      4'b0011: d3k = 3'd3;
      4'b0010: d3k = 3'd4;
      4'b1010: d3k = 3'd5;
      4'b0110: d3k = 3'd6;
      4'b1000: d3k = 3'd7;
      default: ok4k = 1'b0;
    endcase
  end
  // A7 replaces P7 only for D17/18/20 (0111) and D11/13/14 (1000); after x=23/27/29/30 it means K.x.7
  assign a7 = s4 == 4'b0111 || s4 == 4'b1000;
  assign sa = d5 inside {5'd17, 5'd18, 5'd20};
  assign sb = d5 inside {5'd11, 5'd13, 5'd14};
  assign sk = d5 inside {5'd23, 5'd27, 5'd29, 5'd30};
  assign kx7 = a7 && sk;
  assign ok4d = s4 != 4'b0000 && s4 != 4'b1111 && !(s4 == 4'b1110 && sa) && !(s4 == 4'b0001 && sb)
              && (!a7 || (s4 == 4'b0111 && sa) || (s4 == 4'b1000 && sb));
  assign ok = ok6 && (k28 ? ok4k : kx7 || ok4d);
  assign k = k28 || kx7;
  assign d3 = k28 ? d3k : kx7 ? 3'd7 : d3d;
endmodule

// File: rtl/rx_decoder_10b8b.sv
// rx_decoder_10b8b: 8b/10b receive decoder with running disparity, error flags and symbol-lock FSM
//   Recovered_Word_Clk : symbol clock   Rst_n : asynchronous active-low reset
//   rx : slave side of rx_decoder_10b8b_if (symbol + comma flag in, decoded byte/flags/RxValid out)
module rx_decoder_10b8b
  import rx_pcs_pkg::*;
#(
  parameter int ERR_THRESH = 4
) (
  input logic                Recovered_Word_Clk,
  input logic                Rst_n,
  rx_decoder_10b8b_if.slave  rx
);
  localparam logic [3:0] TH1 = 4'(ERR_THRESH - 1);
  logic [9:0] sym_q;
  logic k_q, v_q, rd, rd_mid, rd_end, rd_next, comma, raw_disp, disp_err, dec_err, err, hit;
  logic k, ok;
  logic [4:0] d5;
  logic [2:0] d3;
  disp_e c6, c4;
  lock_e state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [7:0] dout;
  logic dk, dec_q, disp_q;
  dec_10b8b_lut u_lut (.sym(sym_q), .d5(d5), .d3(d3), .k(k), .ok(ok), .c6(c6), .c4(c4));
  // Input capture stage; v_q keeps the post-reset empty stage from being decoded
  always_ff @(posedge Recovered_Word_Clk or negedge Rst_n)
    if (!Rst_n) begin
      sym_q <= 10'd0;
      k_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      sym_q <= rx.Data_to_Decoder;
      k_q <= rx.K285;
      v_q <= 1'b1;
    end
  always_comb begin
    rd_mid = c6 == DISP_P2 || c6 == DISP_0P ? 1'b1 : c6 == DISP_M2 || c6 == DISP_0N ? 1'b0 : rd;
    rd_end = c4 == DISP_P2 || c4 == DISP_0P ? 1'b1 : c4 == DISP_M2 || c4 == DISP_0N ? 1'b0 : rd_mid;
    raw_disp = (c6 == DISP_P2 && rd) || (c6 == DISP_M2 && !rd) || (c4 == DISP_P2 && rd_mid) || (c4 == DISP_M2 && !rd_mid);
    comma = k_q && (sym_q == K28_5_RDN || sym_q == K28_5_RDP);
    disp_err = raw_disp && !comma;
    dec_err = !ok;
    err = dec_err || disp_err;
    rd_next = comma ? sym_q == K28_5_RDN : rd_end;
    hit = state == LOCKED && err && cnt == TH1;
    state_next = comma ? LOCKED : hit ? UNLOCKED : state;
    cnt_next = state == LOCKED && err && !hit ? cnt + 4'd1 : 4'd0;
  end
  always_ff @(posedge Recovered_Word_Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= UNLOCKED;
      cnt <= 4'd0;
      rd <= 1'b0;
      dout <= 8'h00;
      dk <= 1'b0;
      dec_q <= 1'b0;
      disp_q <= 1'b0;
    end else if (v_q) begin
      state <= state_next;
      cnt <= cnt_next;
      rd <= rd_next;
      dout <= dec_err ? EDB_BYTE : {d3, d5};
      dk <= dec_err || k;
      dec_q <= dec_err;
      disp_q <= disp_err;
    end
  assign rx.Data_out = dout;
  assign rx.DataK = dk;
  assign rx.Decode_Error = dec_q;
  assign rx.Disparity_Error = disp_q;
  assign rx.RxValid = state == LOCKED;
endmodule
